// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the 2-input gate self-test sequencer.
package gate_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        CHECK  = 3'd4
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Truth tables indexed by {B, A}
    localparam logic [NUM_VECTORS-1:0] TT_AND = 4'b1000;
    localparam logic [NUM_VECTORS-1:0] TT_OR  = 4'b1110;
    localparam logic [NUM_VECTORS-1:0] TT_XOR = 4'b0110;

endpackage

// File: rtl/gate_sweep_ctrl.sv
// Built-in self-test sequencer: walks all four input vectors of a 2-input gate,
// captures its truth table, and compares it against EXPECTED.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       cont,
    input  logic       gate_out,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] truth_table,
    output logic [7:0] err_count
);

    localparam logic [1:0] LAST_VEC = 2'(NUM_VECTORS - 1);

    state_t     state;
    logic [1:0] vec;
    logic [7:0] cnt;
    logic [1:0] vec_nxt;

    assign vec_nxt = vec + 2'd1;
    assign busy    = (state != IDLE);
    assign done    = (state == CHECK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            vec         <= 2'd0;
            cnt         <= 8'd0;
            gate_a      <= 1'b0;
            gate_b      <= 1'b0;
            pass        <= 1'b0;
            truth_table <= 4'd0;
            err_count   <= 8'd0;
        end else if (state != IDLE && abort) begin
            // Partial truth table, pass and err_count are deliberately kept
            state  <= IDLE;
            gate_a <= 1'b0;
            gate_b <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gate_a <= 1'b0;
                    gate_b <= 1'b0;
                    if (start && !abort) begin
                        vec         <= 2'd0;
                        truth_table <= 4'd0;
                        state       <= APPLY;
                    end
                end
                APPLY: begin
                    cnt   <= 8'(SETTLE_CYCLES);
                    state <= SETTLE;
                end
                SETTLE: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    truth_table[vec] <= gate_out;
                    if (vec == LAST_VEC) begin
                        state <= CHECK;
                    end else begin
                        vec    <= vec_nxt;
                        gate_a <= vec_nxt[0];
                        gate_b <= vec_nxt[1];
                        state  <= APPLY;
                    end
                end
                CHECK: begin
                    pass <= (truth_table == EXPECTED);
                    if (truth_table != EXPECTED && err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                    vec    <= 2'd0;
                    gate_a <= 1'b0;
                    gate_b <= 1'b0;
                    if (cont) begin
                        truth_table <= 4'd0;
                        state       <= APPLY;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: table of full sweeps plus hand sequences
// for abort, continuous mode, saturation and asynchronous reset.
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0: default parameters
    logic       start0 = 0, abort0 = 0, cont0 = 0;
    logic [3:0] func0 = TT_AND;
    logic       gate_out0, gate_a0, gate_b0, busy0, done0, pass0;
    logic [3:0] tt0;
    logic [7:0] err0;
    assign gate_out0 = func0[{gate_b0, gate_a0}];

    gate_sweep_ctrl u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .cont(cont0),
        .gate_out(gate_out0), .gate_a(gate_a0), .gate_b(gate_b0), .busy(busy0),
        .done(done0), .pass(pass0), .truth_table(tt0), .err_count(err0)
    );

    // Instance 1: shortest settle, used for continuous-mode period
    logic       start1 = 0, abort1 = 0, cont1 = 0;
    logic       gate_out1, gate_a1, gate_b1, busy1, done1, pass1;
    logic [3:0] tt1;
    logic [7:0] err1;
    assign gate_out1 = gate_a1 & gate_b1;

    gate_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(TT_AND)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .cont(cont1),
        .gate_out(gate_out1), .gate_a(gate_a1), .gate_b(gate_b1), .busy(busy1),
        .done(done1), .pass(pass1), .truth_table(tt1), .err_count(err1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulses start on instance 0, returns cycles from the start edge to done
    // (-1 on timeout), then steps past CHECK.
    task automatic run_sweep(output int lat);
        start0 = 1;
        tick();
        start0 = 0;
        lat = -1;
        for (int t = 1; t <= 200; t++) begin
            if (done0) begin
                lat = t;
                break;
            end
            tick();
        end
        tick();
    endtask

    typedef struct {
        logic [3:0] func;
        logic [3:0] exp_tt;
        logic       exp_pass;
        logic [7:0] exp_err;
    } sweep_vec_t;

    sweep_vec_t tbl [5];

    initial begin
        int lat;
        int n;
        int cyc;
        logic busy_drop;

        tbl[0] = '{4'b1000, 4'b1000, 1'b1, 8'd0};
        tbl[1] = '{4'b0110, 4'b0110, 1'b0, 8'd1};
        tbl[2] = '{4'b1110, 4'b1110, 1'b0, 8'd2};
        tbl[3] = '{4'b1111, 4'b1111, 1'b0, 8'd3};
        tbl[4] = '{4'b1000, 4'b1000, 1'b1, 8'd3};

        tick(); tick();
        check("reset_busy", 32'(busy0), 0);
        check("reset_outs", {gate_a0, gate_b0, done0, pass0, tt0, err0}, 0);
        rst = 0;
        tick();
        check("idle_busy", 32'(busy0), 0);

        // AND sweep, vector stepping and done latency
        func0 = TT_AND;
        start0 = 1;
        tick();
        start0 = 0;
        for (int t = 1; t <= 16; t++) begin
            check($sformatf("and_vec_t%0d", t), {30'd0, gate_b0, gate_a0}, 32'((t - 1) / 4));
            check($sformatf("and_nodone_t%0d", t), 32'(done0), 0);
            check($sformatf("and_busy_t%0d", t), 32'(busy0), 1);
            tick();
        end
        check("and_done_17", 32'(done0), 1);
        tick();
        check("and_tt", 32'(tt0), 32'h8);
        check("and_pass", 32'(pass0), 1);
        check("and_err", 32'(err0), 0);
        check("and_idle", 32'(busy0), 0);
        check("and_done_pulse", 32'(done0), 0);
        check("and_gates_idle", {gate_a0, gate_b0}, 0);

        for (int i = 0; i < 5; i++) begin
            func0 = tbl[i].func;
            run_sweep(lat);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 17);
            check($sformatf("tbl%0d_tt", i), 32'(tt0), 32'(tbl[i].exp_tt));
            check($sformatf("tbl%0d_pass", i), 32'(pass0), 32'(tbl[i].exp_pass));
            check($sformatf("tbl%0d_err", i), 32'(err0), 32'(tbl[i].exp_err));
        end

        // Abort in SETTLE of vector 2 (cycle k+10)
        func0 = TT_OR;
        start0 = 1;
        tick();
        start0 = 0;
        for (int t = 1; t < 10; t++) tick();
        check("abort_pre_state", {gate_b0, gate_a0, busy0}, 3'b101);
        abort0 = 1;
        tick();
        abort0 = 0;
        check("abort_busy", 32'(busy0), 0);
        check("abort_done", 32'(done0), 0);
        check("abort_gates", {gate_a0, gate_b0}, 0);
        check("abort_tt", 32'(tt0), 32'h2);
        check("abort_pass", 32'(pass0), 1);
        check("abort_err", 32'(err0), 3);
        for (int t = 0; t < 20; t++) begin
            check("abort_no_done", {done0, busy0}, 0);
            tick();
        end

        // start while busy is ignored
        func0 = TT_AND;
        start0 = 1;
        tick();
        start0 = 0;
        lat = -1;
        for (int t = 1; t <= 200; t++) begin
            if (t == 5 || t == 11) start0 = 1;
            if (done0) begin
                lat = t;
                start0 = 0;
                break;
            end
            tick();
            start0 = 0;
        end
        check("busy_start_lat", 32'(lat), 17);
        tick();
        check("busy_start_pass", {busy0, pass0, tt0}, {2'b01, 4'h8});

        // start+abort together in IDLE
        start0 = 1;
        abort0 = 1;
        tick();
        check("start_abort_busy0", 32'(busy0), 0);
        start0 = 0;
        abort0 = 0;
        tick();
        check("start_abort_busy1", 32'(busy0), 0);

        // Stuck-at-0 from fresh reset
        rst = 1;
        tick();
        rst = 0;
        tick();
        func0 = 4'b0000;
        run_sweep(lat);
        check("stuck_tt", 32'(tt0), 0);
        check("stuck_pass", 32'(pass0), 0);
        check("stuck_err1", 32'(err0), 1);
        for (int i = 0; i < 3; i++) run_sweep(lat);
        check("stuck_err4", 32'(err0), 4);

        // 300 failing sweeps in continuous mode saturate err_count
        cont0 = 1;
        start0 = 1;
        tick();
        start0 = 0;
        n = 0;
        cyc = 0;
        while (1) begin
            if (done0) n++;
            if (n == 300 || cyc > 10000) break;
            tick();
            cyc++;
        end
        cont0 = 0;
        tick();
        check("sat_sweeps", 32'(n), 300);
        check("sat_err", 32'(err0), 255);
        check("sat_idle", 32'(busy0), 0);

        func0 = TT_AND;
        run_sweep(lat);
        check("post_sat_pass", {pass0, err0}, {1'b1, 8'hFF});

        // Asynchronous reset during SAMPLE of vector 1 (cycle k+8)
        start0 = 1;
        tick();
        start0 = 0;
        for (int t = 1; t < 8; t++) tick();
        check("pre_rst_gate_a", {gate_b0, gate_a0, busy0}, 3'b011);
        #2;
        rst = 1;
        #1;
        check("async_rst_outs", {gate_a0, gate_b0, busy0, done0, pass0, tt0, err0}, 0);
        #2;
        rst = 0;
        tick();
        run_sweep(lat);
        check("post_rst_lat", 32'(lat), 17);
        check("post_rst_pass", {pass0, tt0, err0}, {1'b1, 4'h8, 8'h00});

        // Continuous mode on SETTLE_CYCLES=1: 13-cycle period, busy never drops
        cont1 = 1;
        start1 = 1;
        tick();
        start1 = 0;
        n = 1;
        while (!done1 && n < 100) begin
            tick();
            n++;
        end
        check("cont_first_done", 32'(n), 13);
        busy_drop = 0;
        for (int p = 0; p < 3; p++) begin
            n = 0;
            do begin
                tick();
                n++;
                if (!busy1) busy_drop = 1;
            end while (!done1 && n < 100);
            check($sformatf("cont_period%0d", p), 32'(n), 13);
            check($sformatf("cont_pass%0d", p), 32'(pass1), 1);
        end
        check("cont_busy_held", 32'(busy_drop), 0);
        tick();
        cont1 = 0;
        n = 1;
        while (!done1 && n < 100) begin
            tick();
            n++;
        end
        check("cont_stop_done", 32'(n), 13);
        tick();
        check("cont_stop_idle", 32'(busy1), 0);
        check("cont_err", 32'(err1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer that exhaustively exercises the 2-input logic gate in `user_module` (A on `ui_in[0]`, B on `ui_in[1]`, result on `uo_out[0]`). On request it applies all four input vectors, waits a programmable settle time per vector, and captures the gate output into a 4-bit truth table. It then compares the table with an expected value and reports pass/fail. It sits between on-chip control logic and the gate inputs, as the gate's built-in self-test controller.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles held in SETTLE per vector; legal range 1..255.
- `EXPECTED`, default 4'b1000: expected truth table; bit i is the gate output for A=i[0], B=i[1] (AND function).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `abort`  in  1  cancel the sweep in progress.
- `cont`  in  1  continuous mode; sampled in CHECK.
- `gate_out`  in  1  gate result (`uo_out[0]`).
- `gate_a`  out  1  gate input A (drives `ui_in[0]`), registered.
- `gate_b`  out  1  gate input B (drives `ui_in[1]`), registered.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at sweep completion.
- `pass`  out  1  result of the last completed sweep.
- `truth_table`  out  4  captured outputs, indexed by vector.
- `err_count`  out  8  failed-sweep count, saturating.

## Operation
- States: IDLE, APPLY, SETTLE, SAMPLE, CHECK. Internal state: 2-bit vector index `vec` and an 8-bit settle counter.
- IDLE: `gate_a`=`gate_b`=0. If `start`=1 and `abort`=0:
  - `vec`←0, `truth_table`←0, `gate_a`/`gate_b`←0.
  - Go to APPLY.
- APPLY (1 cycle): counter←`SETTLE_CYCLES`. Go to SETTLE.
- SETTLE: counter decrements each cycle. After exactly `SETTLE_CYCLES` cycles, go to SAMPLE.
- SAMPLE (1 cycle): `truth_table[vec]`←`gate_out`.
  - If `vec`=3, go to CHECK.
  - Otherwise `vec`←`vec`+1, drive `gate_a`←new `vec[0]` and `gate_b`←new `vec[1]` on that same edge, and go to APPLY.
- CHECK (1 cycle): `done`=1 combinationally from state. On exit:
  - `pass`←(`truth_table`==`EXPECTED`).
  - On mismatch, `err_count`←`err_count`+1, saturating at 255.
  - If `cont`=1: `vec`←0, `gate_a`/`gate_b`←0, `truth_table`←0, go to APPLY.
  - Otherwise return to IDLE.
- `abort` in any non-IDLE state: IDLE on the next edge.
  - `done` not pulsed; `pass` and `err_count` unchanged.
  - `truth_table` keeps its partial contents.
  - `gate_a`/`gate_b`←0.
- `abort` has priority over all other transitions, including CHECK→APPLY.
- `start` while busy is ignored.
- `start` and `abort` both high in IDLE: remain in IDLE.
- `err_count` is cleared only by `rst`.

## Timing
- Reset values: state IDLE, `gate_a`=0, `gate_b`=0, `busy`=0, `done`=0, `pass`=0, `truth_table`=0, `err_count`=0, `vec`=0, counter=0.
- Reset is asynchronous on assertion, including mid-sweep: all outputs take reset values immediately.
- Each vector takes `SETTLE_CYCLES`+2 cycles (APPLY + SETTLE + SAMPLE).
- `start` sampled at edge k: APPLY occupies cycle k+1, and `done` is high in cycle k+1+4·(`SETTLE_CYCLES`+2). With the default, that is 17 cycles after edge k.
- `pass`/`err_count` update on the edge that ends CHECK and hold until the next CHECK exit.
- `gate_a`/`gate_b` are stable from APPLY through SAMPLE for each vector; the gate sees each vector for at least `SETTLE_CYCLES`+1 edges before capture.
- Continuous mode: no idle cycle between sweeps. The next APPLY follows CHECK directly, so the sweep period is 4·(S+2)+1 cycles.

## Structure
- Package `gate_sweep_pkg`:
  - state enum (IDLE, APPLY, SETTLE, SAMPLE, CHECK);
  - `NUM_VECTORS`=4;
  - `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_XOR`=4'b0110.
- Single module; the settle counter and FSM are inline, no sub-module.

## Test plan
- AND gate, default parameters, single `start` pulse:
  - gate_a/gate_b step 00→10→01→11;
  - `done` high exactly 17 cycles after the start edge;
  - `truth_table`=4'b1000, `pass`=1, `err_count`=0.
- Stuck-at-0 model on `gate_out`: `truth_table`=0000, `pass`=0, `err_count`=1. Three more sweeps give `err_count`=4. After 300 failing sweeps in `cont` mode, `err_count`=255.
- `abort` asserted during the SETTLE of vector 2:
  - IDLE next cycle, no `done`, `gate_a`=`gate_b`=0;
  - `pass` keeps its prior value;
  - `truth_table` bits 0..1 captured, bits 2..3 = 0.
- `cont`=1 with `SETTLE_CYCLES`=1: `done` pulses every 13 cycles and `busy` never drops. Deassert `cont`: IDLE after the next CHECK.
- `rst` asserted mid-SAMPLE, between clock edges: all outputs go to reset values immediately. `start` then runs a clean sweep with `pass`=1.
- `start` pulsed while busy: no effect on the sequence or timing. `start`+`abort` together in IDLE: `busy` stays 0.
